// File: rtl/side_buffer_reinject.sv
// Drain side of the MinBD side buffer: FIFO of deflected flits re-injected into the
// router when the reinjection slot is free, with a starvation-driven redirection request.
module side_buffer_reinject #(
    parameter int FLIT_W       = 11,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [FLIT_W-1:0]          wr_flit,
    output logic                       wr_ready,
    input  logic                       slot_free,
    output logic                       reinj_valid,
    output logic [FLIT_W-1:0]          reinj_flit,
    output logic                       redir_req,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    logic [FLIT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;
    logic              reinj_valid_r;
    logic [FLIT_W-1:0] reinj_flit_r;
    logic              overflow_r;
    logic              redir_r;
    logic              redir_nxt_s;
    logic [SW-1:0]     starve_r;
    logic [SW-1:0]     starve_nxt_s;
    logic [SW-1:0]     starve_inc_s;
    state_t            state_r;
    state_t            state_nxt_s;
    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              offered_s;

    assign empty_s     = (count_r == CW'(0));
    assign full_s      = (count_r == CW'(DEPTH));
    assign pop_s       = !empty_s && slot_free;
    assign offered_s   = wr_valid && wr_flit[FLIT_W-1];
    assign push_s      = offered_s && (!full_s || pop_s);
    assign count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
    // Saturating increment so a long starvation cannot wrap the counter.
    assign starve_inc_s = (starve_r == SW'(STARVE_LIMIT)) ? starve_r : starve_r + SW'(1);

    assign wr_ready    = !full_s || pop_s;
    assign count       = count_r;
    assign empty       = empty_s;
    assign full        = full_s;
    assign reinj_valid = reinj_valid_r;
    assign reinj_flit  = reinj_flit_r;
    assign redir_req   = redir_r;
    assign overflow    = overflow_r;

    // FIFO storage; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_flit;
        end
    end

    // Pointers, occupancy and registered reinjection/overflow outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            count_r       <= {CW{1'b0}};
            reinj_valid_r <= 1'b0;
            reinj_flit_r  <= {FLIT_W{1'b0}};
            overflow_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r      <= rd_ptr_r + AW'(1);
                reinj_valid_r <= 1'b1;
                reinj_flit_r  <= mem_r[rd_ptr_r];
            end else begin
                reinj_valid_r <= 1'b0;
                reinj_flit_r  <= {FLIT_W{1'b0}};
            end
            count_r    <= count_nxt_s;
            overflow_r <= offered_s && full_s && !pop_s;
        end
    end

    // Starvation FSM state register, with its counter and request output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= S_EMPTY;
            starve_r <= {SW{1'b0}};
            redir_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            starve_r <= starve_nxt_s;
            redir_r  <= redir_nxt_s;
        end
    end

    // Starvation FSM next-state and counter update.
    always_comb begin
        state_nxt_s  = state_r;
        starve_nxt_s = starve_r;
        case (state_r)
            S_EMPTY: begin
                starve_nxt_s = {SW{1'b0}};
                if (push_s) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_EMPTY;
                end
            end
            S_WAIT: begin
                if (pop_s) begin
                    starve_nxt_s = {SW{1'b0}};
                    if (count_nxt_s == CW'(0)) begin
                        state_nxt_s = S_EMPTY;
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end else if (!empty_s && !slot_free) begin
                    starve_nxt_s = starve_inc_s;
                    if (starve_inc_s == SW'(STARVE_LIMIT)) begin
                        state_nxt_s = S_REDIR;
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end else if (count_nxt_s == CW'(0)) begin
                    state_nxt_s = S_EMPTY;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_REDIR: begin
                if (pop_s) begin
                    starve_nxt_s = {SW{1'b0}};
                    if (count_nxt_s == CW'(0)) begin
                        state_nxt_s = S_EMPTY;
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end else begin
                    starve_nxt_s = starve_inc_s;
                    state_nxt_s  = S_REDIR;
                end
            end
            default: begin
                state_nxt_s  = S_EMPTY;
                starve_nxt_s = {SW{1'b0}};
            end
        endcase
    end

    // Request is high exactly while the FSM sits in S_REDIR.
    always_comb begin
        redir_nxt_s = 1'b0;
        case (state_nxt_s)
            S_REDIR: redir_nxt_s = 1'b1;
            S_EMPTY: redir_nxt_s = 1'b0;
            S_WAIT:  redir_nxt_s = 1'b0;
            default: redir_nxt_s = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_side_buffer_reinject.sv
// Directed bench for side_buffer_reinject with hand-computed expectations.
module tb_side_buffer_reinject;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic [10:0] wr_flit;
    logic        wr_ready;
    logic        slot_free;
    logic        reinj_valid;
    logic [10:0] reinj_flit;
    logic        redir_req;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;

    int checks_r;
    int failures_r;

    side_buffer_reinject #(
        .FLIT_W(11),
        .DEPTH(4),
        .STARVE_LIMIT(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_valid(wr_valid),
        .wr_flit(wr_flit),
        .wr_ready(wr_ready),
        .slot_free(slot_free),
        .reinj_valid(reinj_valid),
        .reinj_flit(reinj_flit),
        .redir_req(redir_req),
        .count(count),
        .empty(empty),
        .full(full),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [10:0] f);
        wr_valid = 1'b1;
        wr_flit  = f;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        checks_r   = 0;
        failures_r = 0;
        rst_n      = 1'b0;
        wr_valid   = 1'b1;
        wr_flit    = 11'h43F;
        slot_free  = 1'b0;

        // Reset with a valid flit offered
        step();
        step();
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_rvalid", 32'(reinj_valid), 32'd0);
        check_eq("rst_redir", 32'(redir_req), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_wready", 32'(wr_ready), 32'd1);

        // Pass-through
        slot_free = 1'b1;
        push_one(11'h435);
        check_eq("pt_count1", 32'(count), 32'd1);
        check_eq("pt_noreinj", 32'(reinj_valid), 32'd0);
        step();
        check_eq("pt_rvalid", 32'(reinj_valid), 32'd1);
        check_eq("pt_rflit", 32'(reinj_flit), 32'h435);
        check_eq("pt_count0", 32'(count), 32'd0);
        step();
        check_eq("pt_rvalid_drop", 32'(reinj_valid), 32'd0);
        check_eq("pt_rflit_zero", 32'(reinj_flit), 32'h0);

        // Fill in order, then overflow
        slot_free = 1'b0;
        push_one(11'h42E);
        push_one(11'h42D);
        push_one(11'h43D);
        push_one(11'h43F);
        check_eq("fill_count", 32'(count), 32'd4);
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_wready", 32'(wr_ready), 32'd0);
        check_eq("fill_redir", 32'(redir_req), 32'd1);
        push_one(11'h401);
        check_eq("ovf_pulse", 32'(overflow), 32'd1);
        check_eq("ovf_count", 32'(count), 32'd4);
        step();
        check_eq("ovf_drop", 32'(overflow), 32'd0);
        slot_free = 1'b1;
        step();
        check_eq("ord0", 32'(reinj_flit), 32'h42E);
        check_eq("ord0_redir", 32'(redir_req), 32'd0);
        check_eq("ord0_count", 32'(count), 32'd3);
        step();
        check_eq("ord1", 32'(reinj_flit), 32'h42D);
        step();
        check_eq("ord2", 32'(reinj_flit), 32'h43D);
        step();
        check_eq("ord3", 32'(reinj_flit), 32'h43F);
        check_eq("ord3_valid", 32'(reinj_valid), 32'd1);
        check_eq("ord_empty", 32'(empty), 32'd1);
        step();
        check_eq("ord_done", 32'(reinj_valid), 32'd0);

        // Starvation of a single flit
        slot_free = 1'b0;
        push_one(11'h5A5);
        step();
        check_eq("stv_1", 32'(redir_req), 32'd0);
        step();
        check_eq("stv_2", 32'(redir_req), 32'd0);
        step();
        check_eq("stv_3", 32'(redir_req), 32'd1);
        step();
        check_eq("stv_hold", 32'(redir_req), 32'd1);
        slot_free = 1'b1;
        step();
        check_eq("stv_pop_flit", 32'(reinj_flit), 32'h5A5);
        check_eq("stv_pop_valid", 32'(reinj_valid), 32'd1);
        check_eq("stv_clear", 32'(redir_req), 32'd0);
        check_eq("stv_count", 32'(count), 32'd0);
        step();

        // Full with simultaneous push and pop, then an invalid-bit flit
        slot_free = 1'b0;
        push_one(11'h411);
        push_one(11'h422);
        push_one(11'h433);
        push_one(11'h444);
        check_eq("fp_full", 32'(full), 32'd1);
        slot_free = 1'b1;
        wr_valid  = 1'b1;
        wr_flit   = 11'h455;
        #1;
        check_eq("fp_wready", 32'(wr_ready), 32'd1);
        step();
        check_eq("fp_count", 32'(count), 32'd4);
        check_eq("fp_head", 32'(reinj_flit), 32'h411);
        check_eq("fp_noovf", 32'(overflow), 32'd0);
        wr_flit = 11'h035;
        step();
        wr_valid = 1'b0;
        check_eq("inv_noovf", 32'(overflow), 32'd0);
        check_eq("inv_count", 32'(count), 32'd3);
        check_eq("fp_pop1", 32'(reinj_flit), 32'h422);
        step();
        check_eq("fp_pop2", 32'(reinj_flit), 32'h433);
        step();
        check_eq("fp_pop3", 32'(reinj_flit), 32'h444);
        step();
        check_eq("fp_pop4", 32'(reinj_flit), 32'h455);
        check_eq("fp_empty", 32'(count), 32'd0);
        step();
        check_eq("fp_done", 32'(reinj_valid), 32'd0);

        // Reset mid-operation
        slot_free = 1'b0;
        push_one(11'h466);
        push_one(11'h477);
        push_one(11'h488);
        step();
        check_eq("mr_redir", 32'(redir_req), 32'd1);
        check_eq("mr_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("mr_count0", 32'(count), 32'd0);
        check_eq("mr_empty", 32'(empty), 32'd1);
        check_eq("mr_redir0", 32'(redir_req), 32'd0);
        check_eq("mr_rvalid0", 32'(reinj_valid), 32'd0);
        check_eq("mr_rflit0", 32'(reinj_flit), 32'h0);
        check_eq("mr_ovf0", 32'(overflow), 32'd0);
        slot_free = 1'b1;
        push_one(11'h499);
        check_eq("mr_count1", 32'(count), 32'd1);
        step();
        check_eq("mr_new_flit", 32'(reinj_flit), 32'h499);
        check_eq("mr_new_valid", 32'(reinj_valid), 32'd1);
        step();
        check_eq("mr_after", 32'(reinj_valid), 32'd0);
        check_eq("mr_after_cnt", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
